// File: rtl/muldiv_arbiter_if.sv
// rtl/muldiv_arbiter_if.sv - request/response channel of one muldiv_arbiter port
// master = requester side, slave = arbiter side.
interface muldiv_arbiter_if;
  logic        valid;
  logic        ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op_mul;
  logic [1:0]  op_div;
  logic        sel;
  logic        rvalid;
  logic        rready;
  logic [31:0] result;
  logic        err;

  modport master (
    output valid, a, b, op_mul, op_div, sel, rready,
    input  ready, rvalid, result, err
  );

  modport slave (
    input  valid, a, b, op_mul, op_div, sel, rready,
    output ready, rvalid, result, err
  );
endinterface

// File: rtl/muldiv_arbiter.sv
// rtl/muldiv_arbiter.sv - two-port arbiter sequencing one shared multiply/divide unit
// Optional last-result cache enabled by defining MULDIV_LAST_RESULT_CACHE_EN.
module muldiv_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit FIXED_PRIO     = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  muldiv_arbiter_if.slave r0,
  muldiv_arbiter_if.slave r1,
  output logic            md_start,
  output logic [31:0]     md_in_A,
  output logic [31:0]     md_in_B,
  output logic [1:0]      md_op_mul,
  output logic [1:0]      md_op_div,
  output logic            md_sel,
  input  logic [31:0]     md_R,
  input  logic            md_done,
  output logic            busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic          owner;
  logic          ptr;
  logic [31:0]   result_q;
  logic          err_q;

  logic          grant_any;
  logic          grant1;
  logic          cache_hit;
  logic [31:0]   cache_data;
  logic          owner_rready;
  logic          timed_out;
  logic          resp0;
  logic          resp1;
  logic [31:0]   req_a;
  logic [31:0]   req_b;
  logic [1:0]    req_om;
  logic [1:0]    req_od;
  logic          req_sel;

  // Grant is only offered in IDLE; ptr names the port that wins a tie in round-robin mode.
  always_comb begin
    grant_any = 1'b0;
    grant1    = 1'b0;
    if (state == S_IDLE) begin
      if (FIXED_PRIO || !ptr) begin
        if (r0.valid) begin
          grant_any = 1'b1;
        end else if (r1.valid) begin
          grant_any = 1'b1;
          grant1    = 1'b1;
        end
      end else begin
        if (r1.valid) begin
          grant_any = 1'b1;
          grant1    = 1'b1;
        end else if (r0.valid) begin
          grant_any = 1'b1;
        end
      end
    end
  end

  assign r0.ready = grant_any & ~grant1;
  assign r1.ready = grant_any & grant1;

  assign req_a   = grant1 ? r1.a      : r0.a;
  assign req_b   = grant1 ? r1.b      : r0.b;
  assign req_om  = grant1 ? r1.op_mul : r0.op_mul;
  assign req_od  = grant1 ? r1.op_div : r0.op_div;
  assign req_sel = grant1 ? r1.sel    : r0.sel;

  assign owner_rready = owner ? r1.rready : r0.rready;
  assign timed_out    = (timer == TMAX);

`ifdef MULDIV_LAST_RESULT_CACHE_EN
  logic        cache_valid;
  logic [31:0] cache_a;
  logic [31:0] cache_b;
  logic [1:0]  cache_om;
  logic [1:0]  cache_od;
  logic        cache_sel;
  logic [31:0] cache_result;

  assign cache_hit = cache_valid && (req_a == cache_a) && (req_b == cache_b) &&
                     (req_om == cache_om) && (req_od == cache_od) && (req_sel == cache_sel);
  assign cache_data = cache_result;

  // md_* registers still hold the completing op's fields while in WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_valid  <= 1'b0;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_om     <= '0;
      cache_od     <= '0;
      cache_sel    <= 1'b0;
      cache_result <= '0;
    end else if (state == S_WAIT) begin
      if (md_done) begin
        cache_valid  <= 1'b1;
        cache_a      <= md_in_A;
        cache_b      <= md_in_B;
        cache_om     <= md_op_mul;
        cache_od     <= md_op_div;
        cache_sel    <= md_sel;
        cache_result <= md_R;
      end else if (timed_out) begin
        cache_valid <= 1'b0;
      end
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (grant_any) state_next = cache_hit ? S_RESP : S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (md_done || timed_out) state_next = S_RESP;
      S_RESP:  if (owner_rready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_in_A   <= '0;
      md_in_B   <= '0;
      md_op_mul <= '0;
      md_op_div <= '0;
      md_sel    <= 1'b0;
      owner     <= 1'b0;
      ptr       <= 1'b0;
      timer     <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant_any) begin
            md_in_A   <= req_a;
            md_in_B   <= req_b;
            md_op_mul <= req_om;
            md_op_div <= req_od;
            md_sel    <= req_sel;
            owner     <= grant1;
            result_q  <= cache_data;
            err_q     <= 1'b0;
          end
        end
        S_ISSUE: timer <= '0;
        // A completion in the timeout cycle still counts as success.
        S_WAIT: begin
          if (md_done) begin
            result_q <= md_R;
            err_q    <= 1'b0;
          end else if (timed_out) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_RESP: if (owner_rready) ptr <= ~owner;
        default: ;
      endcase
    end
  end

  assign resp0 = (state == S_RESP) && !owner;
  assign resp1 = (state == S_RESP) && owner;

  assign r0.rvalid = resp0;
  assign r1.rvalid = resp1;
  assign r0.result = resp0 ? result_q : '0;
  assign r1.result = resp1 ? result_q : '0;
  assign r0.err    = resp0 & err_q;
  assign r1.err    = resp1 & err_q;

  assign md_start = (state == S_ISSUE);
  assign busy     = (state != S_IDLE);
endmodule
